// File: rtl/mac_operand_sequencer_if.sv
// Operand-load, MAC and result-stream signals of the MAC operand sequencer.
// The slave side is the sequencer; the master side drives loads, starts runs and consumes results.
interface mac_operand_sequencer_if;
  logic         ld_valid;
  logic         ld_sel;
  logic [3:0]   ld_idx;
  logic [3:0]   ld_k;
  logic [7:0]   ld_data;
  logic         start;
  logic         busy;
  logic         done;
  logic [127:0] mac_a_vec;
  logic [127:0] mac_b_vec;
  logic [19:0]  mac_out;
  logic         res_valid;
  logic         res_ready;
  logic [19:0]  res_data;
  logic [3:0]   res_row;
  logic [3:0]   res_col;
  logic         res_last;

  modport slave (
    input  ld_valid, ld_sel, ld_idx, ld_k, ld_data, start, mac_out, res_ready,
    output busy, done, mac_a_vec, mac_b_vec, res_valid, res_data, res_row, res_col, res_last
  );

  modport master (
    output ld_valid, ld_sel, ld_idx, ld_k, ld_data, start, mac_out, res_ready,
    input  busy, done, mac_a_vec, mac_b_vec, res_valid, res_data, res_row, res_col, res_last
  );
endinterface

// File: rtl/mac_operand_sequencer.sv
// Feeds A-row/B-column operand pairs to a 16-term MAC and streams C = A*B row-major.
// Issue is credit-gated so the result FIFO can never overflow and the MAC never stalls.
module mac_operand_sequencer #(
  parameter int ROWS     = 4,
  parameter int COLS     = 4,
  parameter int MAC_LAT  = 2,
  parameter int FIFO_DEP = 4
) (
  input logic clk,
  input logic reset,
  mac_operand_sequencer_if.slave bus
);
  localparam int CW = $clog2(FIFO_DEP + 1);
  localparam int PW = $clog2(FIFO_DEP);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  typedef struct packed {
    logic [3:0] row;
    logic [3:0] col;
    logic       last;
  } tag_t;
  typedef struct packed {
    logic [19:0] data;
    tag_t        tag;
  } ent_t;

  state_t state, state_nxt;
  logic [ROWS-1:0][127:0] a_bank;
  logic [COLS-1:0][127:0] b_bank;
  logic [127:0] a_row, b_col, a_vec, b_vec;
  logic [3:0]   i_q, j_q;
  logic [MAC_LAT:0] vld_pipe;
  tag_t tag_pipe [MAC_LAT+1];
  ent_t fifo [FIFO_DEP];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, in_flight;
  logic [CW:0]   occ;
  logic issue, issue_last, push, pop, res_valid, drain_done;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEP-1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    in_flight = '0;
    for (int s = 0; s <= MAC_LAT; s++) in_flight = in_flight + CW'(vld_pipe[s]);
  end

  assign res_valid  = (count != '0);
  assign push       = vld_pipe[MAC_LAT];
  assign pop        = res_valid && bus.res_ready;
  // A pop this cycle returns its credit immediately.
  assign occ        = {1'b0, in_flight} + {1'b0, count} - {{CW{1'b0}}, pop};
  assign issue      = (state == RUN) && (occ < (CW+1)'(FIFO_DEP));
  assign issue_last = (i_q == 4'(ROWS-1)) && (j_q == 4'(COLS-1));
  assign drain_done = (state == DRAIN) && (in_flight == '0) && (count == CW'(1)) && pop;

  always_comb begin
    a_row = '0;
    b_col = '0;
    for (int r = 0; r < ROWS; r++) if (i_q == 4'(r)) a_row = a_bank[r];
    for (int c = 0; c < COLS; c++) if (j_q == 4'(c)) b_col = b_bank[c];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (bus.start)            state_nxt = RUN;
      RUN:     if (issue && issue_last)  state_nxt = DRAIN;
      DRAIN:   if (drain_done)           state_nxt = IDLE;
      default:                           state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      i_q <= '0;
      j_q <= '0;
    end else if (state == IDLE && bus.start) begin
      i_q <= '0;
      j_q <= '0;
    end else if (issue) begin
      if (j_q == 4'(COLS-1)) begin
        j_q <= '0;
        i_q <= i_q + 4'd1;
      end else begin
        j_q <= j_q + 4'd1;
      end
    end
  end

  // Banks are only writable between runs so a run sees a consistent snapshot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_bank <= '0;
      b_bank <= '0;
    end else if (state == IDLE && bus.ld_valid) begin
      for (int r = 0; r < ROWS; r++)
        if (!bus.ld_sel && bus.ld_idx == 4'(r)) a_bank[r][{bus.ld_k, 3'b000} +: 8] <= bus.ld_data;
      for (int c = 0; c < COLS; c++)
        if (bus.ld_sel && bus.ld_idx == 4'(c))  b_bank[c][{bus.ld_k, 3'b000} +: 8] <= bus.ld_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_vec    <= '0;
      b_vec    <= '0;
      vld_pipe <= '0;
      for (int s = 0; s <= MAC_LAT; s++) tag_pipe[s] <= '0;
    end else begin
      if (issue) begin
        a_vec <= a_row;
        b_vec <= b_col;
      end
      vld_pipe[0] <= issue;
      tag_pipe[0] <= '{row: i_q, col: j_q, last: issue_last};
      for (int s = 1; s <= MAC_LAT; s++) begin
        vld_pipe[s] <= vld_pipe[s-1];
        tag_pipe[s] <= tag_pipe[s-1];
      end
    end
  end

  // The tag leaves the pipe in the cycle mac_out holds the matching result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int e = 0; e < FIFO_DEP; e++) fifo[e] <= '0;
    end else begin
      if (push) begin
        fifo[wr_ptr] <= '{data: bus.mac_out, tag: tag_pipe[MAC_LAT]};
        wr_ptr       <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign bus.busy      = (state != IDLE);
  assign bus.done      = drain_done;
  assign bus.mac_a_vec = a_vec;
  assign bus.mac_b_vec = b_vec;
  assign bus.res_valid = res_valid;
  assign bus.res_data  = fifo[rd_ptr].data;
  assign bus.res_row   = fifo[rd_ptr].tag.row;
  assign bus.res_col   = fifo[rd_ptr].tag.col;
  assign bus.res_last  = fifo[rd_ptr].tag.last;
endmodule
